// File: rtl/alu_simd_pkg.sv
// Shared encodings for the pipelined SIMD post-adder ALU.
package alu_simd_pkg;

  localparam logic [3:0] ALU_ZPT = 4'b0000; // Z + T
  localparam logic [3:0] ALU_TMZ = 4'b0001; // ~Z + T
  localparam logic [3:0] ALU_NZT = 4'b0010; // ~(Z + T)
  localparam logic [3:0] ALU_ZMT = 4'b0011; // ~(~Z + T) = Z - T
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_SEG  = 2'b10;
  localparam logic [1:0] MODE_BAD  = 2'b11;

  // True when segment k is the most significant segment of its lane.
  function automatic logic seg_is_top(input logic [1:0] mode, input int unsigned k,
                                      input int unsigned n);
    case (mode)
      MODE_HALF: return (k == n / 2 - 1) || (k == n - 1);
      MODE_SEG:  return 1'b1;
      default:   return k == n - 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_simd_seg.sv
// One segment of the four-operand adder; the 2-bit carry chains to the next segment.
module alu_simd_seg #(
  parameter int unsigned SEG_W = 12
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] w_i,
  input  logic [SEG_W-1:0] x_i,
  input  logic [SEG_W-1:0] y_i,
  input  logic [1:0]       cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic [1:0]       cout_o
);

  // Four full-scale operands plus a carry of at most 3 fit exactly in SEG_W+2 bits.
  logic [SEG_W+1:0] total;

  assign total = {2'b00, a_i} + {2'b00, w_i} + {2'b00, x_i} + {2'b00, y_i}
               + {{SEG_W{1'b0}}, cin_i};
  assign sum_o  = total[SEG_W-1:0];
  assign cout_o = total[SEG_W+1:SEG_W];

endmodule

// File: rtl/alu_simd_pipe.sv
// Two-stage SIMD four-operand ALU with accumulator feedback and per-lane carries.
module alu_simd_pipe
  import alu_simd_pkg::*;
#(
  parameter int unsigned SEG_W   = 12,
  parameter int unsigned NUM_SEG = 4,
  localparam int unsigned DW     = SEG_W * NUM_SEG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [3:0]           ALUMODE,
  input  logic [1:0]           USE_SIMD,
  input  logic                 ACC,
  input  logic                 CIN,
  input  logic [DW-1:0]        W,
  input  logic [DW-1:0]        X,
  input  logic [DW-1:0]        Y,
  input  logic [DW-1:0]        Z,
  output logic [DW-1:0]        S,
  output logic                 out_valid,
  output logic [2*NUM_SEG-1:0] carry_out,
  output logic                 cfg_err
);

  logic [DW-1:0]        w_q, x_q, y_q, z_q;
  logic [3:0]           alumode_q;
  logic [1:0]           use_simd_q;
  logic                 acc_q, cin_q, v1_q;
  logic [DW-1:0]        s_q;
  logic [2*NUM_SEG-1:0] carry_q;
  logic                 out_valid_q, cfg_err_q;

  logic [1:0]           mode_eff;
  logic [NUM_SEG-1:0]   seg_top;
  logic [DW-1:0]        z_eff, a_op, raw_sum, result;
  logic [2*NUM_SEG-1:0] raw_carry, carry_res;
  logic                 invert_z, cin0;

  assign mode_eff = (use_simd_q == MODE_BAD) ? MODE_FULL : use_simd_q;
  assign z_eff    = acc_q ? s_q : z_q;
  assign invert_z = (alumode_q == ALU_ZMT) || (alumode_q == ALU_TMZ);
  assign a_op     = invert_z ? ~z_eff : z_eff;
  assign cin0     = (mode_eff == MODE_FULL) & cin_q;

  always_comb begin
    seg_top = '0;
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      seg_top[k] = seg_is_top(mode_eff, k, NUM_SEG);
    end
  end

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    logic [1:0]       cin;
    logic [1:0]       cout;
    logic [SEG_W-1:0] sum;

    // The carry chain is cut at every lane boundary.
    if (k == 0) begin : g_first
      assign cin = {1'b0, cin0};
    end else begin : g_rest
      assign cin = seg_top[k-1] ? 2'b00 : g_seg[k-1].cout;
    end

    alu_simd_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a_i   (a_op[k*SEG_W +: SEG_W]),
      .w_i   (w_q[k*SEG_W +: SEG_W]),
      .x_i   (x_q[k*SEG_W +: SEG_W]),
      .y_i   (y_q[k*SEG_W +: SEG_W]),
      .cin_i (cin),
      .sum_o (sum),
      .cout_o(cout)
    );

    assign raw_sum[k*SEG_W +: SEG_W] = sum;
    assign raw_carry[2*k +: 2]       = seg_top[k] ? cout : 2'b00;
  end

  always_comb begin
    result    = '0;
    carry_res = '0;
    case (alumode_q)
      ALU_ZPT, ALU_TMZ: begin
        result    = raw_sum;
        carry_res = raw_carry;
      end
      ALU_ZMT, ALU_NZT: begin
        result    = ~raw_sum;
        carry_res = raw_carry;
      end
      ALU_XOR: result = x_q ^ z_eff;
      ALU_AND: result = x_q & z_eff;
      ALU_OR:  result = x_q | z_eff;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      alumode_q   <= '0;
      use_simd_q  <= '0;
      acc_q       <= 1'b0;
      cin_q       <= 1'b0;
      v1_q        <= 1'b0;
      s_q         <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else if (ce) begin
      w_q         <= W;
      x_q         <= X;
      y_q         <= Y;
      z_q         <= Z;
      alumode_q   <= ALUMODE;
      use_simd_q  <= USE_SIMD;
      acc_q       <= ACC;
      cin_q       <= CIN;
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (in_valid && (USE_SIMD == MODE_BAD)) begin
        cfg_err_q <= 1'b1;
      end
      if (v1_q) begin
        s_q     <= result;
        carry_q <= carry_res;
      end
    end
  end

  assign S         = s_q;
  assign carry_out = carry_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_alu_simd_pipe.sv
// Self-checking bench for alu_simd_pipe: directed scenarios plus a lane-level scoreboard model.
module tb_alu_simd_pipe;

  localparam int unsigned SEG_W = 12;
  localparam int unsigned NS    = 4;
  localparam int unsigned DW    = SEG_W * NS;

  logic          clk = 1'b0;
  logic          reset, ce, in_valid, ACC, CIN;
  logic [3:0]    ALUMODE;
  logic [1:0]    USE_SIMD;
  logic [DW-1:0] W, X, Y, Z, S;
  logic          out_valid, cfg_err;
  logic [2*NS-1:0] carry_out;

  typedef struct packed {
    logic [DW-1:0] w, x, y, z;
    logic [3:0]    op;
    logic [1:0]    simd;
    logic          acc, cin;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0]   s;
    logic [2*NS-1:0] c;
  } exp_t;

  exp_t            exp_q[$];
  logic [DW-1:0]   model_s;
  logic [DW-1:0]   last_s;
  logic [2*NS-1:0] last_c;
  int              errors = 0;
  int              checks = 0;

  always #5 clk = ~clk;

  alu_simd_pipe #(
    .SEG_W  (SEG_W),
    .NUM_SEG(NS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .ALUMODE  (ALUMODE),
    .USE_SIMD (USE_SIMD),
    .ACC      (ACC),
    .CIN      (CIN),
    .W        (W),
    .X        (X),
    .Y        (Y),
    .Z        (Z),
    .S        (S),
    .out_valid(out_valid),
    .carry_out(carry_out),
    .cfg_err  (cfg_err)
  );

  // Per-lane arithmetic on whole lanes, independent of the segment carry chain.
  function automatic exp_t model(input beat_t b);
    exp_t        e;
    logic [63:0] m, wl, xl, yl, zl, t, raw, res, rs, zsrc;
    logic [1:0]  md;
    int          nl, lw, lo, top;
    md   = (b.simd == 2'b11) ? 2'b00 : b.simd;
    nl   = (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : NS;
    lw   = DW / nl;
    m    = (64'd1 << lw) - 64'd1;
    rs   = '0;
    e.c  = '0;
    zsrc = {16'b0, (b.acc ? model_s : b.z)};
    for (int l = 0; l < nl; l++) begin
      lo  = l * lw;
      wl  = ({16'b0, b.w} >> lo) & m;
      xl  = ({16'b0, b.x} >> lo) & m;
      yl  = ({16'b0, b.y} >> lo) & m;
      zl  = (zsrc >> lo) & m;
      t   = wl + xl + yl + ((l == 0 && md == 2'b00) ? 64'(b.cin) : 64'd0);
      raw = '0;
      case (b.op)
        4'b0000: begin raw = zl + t;        res = raw;  end
        4'b0011: begin raw = (~zl & m) + t; res = ~raw; end
        4'b0001: begin raw = (~zl & m) + t; res = raw;  end
        4'b0010: begin raw = zl + t;        res = ~raw; end
        4'b0100: res = xl ^ zl;
        4'b1100: res = xl & zl;
        4'b1101: res = xl | zl;
        default: res = '0;
      endcase
      rs  = rs | ((res & m) << lo);
      top = (lo + lw) / int'(SEG_W) - 1;
      e.c[2*top +: 2] = raw[lw +: 2];
    end
    e.s = rs[DW-1:0];
    return e;
  endfunction

  function automatic beat_t mk(input logic [DW-1:0] w, x, y, z, input logic [3:0] op,
                               input logic [1:0] simd, input logic acc, cin);
    beat_t b;
    b.w = w; b.x = x; b.y = y; b.z = z; b.op = op; b.simd = simd; b.acc = acc; b.cin = cin;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    exp_t e;
    W = b.w; X = b.x; Y = b.y; Z = b.z;
    ALUMODE = b.op; USE_SIMD = b.simd; ACC = b.acc; CIN = b.cin;
    in_valid = 1'b1;
    e = model(b);
    exp_q.push_back(e);
    model_s = e.s;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; ALUMODE = 4'b0; USE_SIMD = 2'b0; ACC = 1'b0; CIN = 1'b0;
    W = '0; X = '0; Y = '0; Z = '0;
  endtask

  // One clock; fresh means a new result was loaded at this edge.
  task automatic tick(output bit fresh);
    bit pre;
    pre = ce && !reset;
    @(posedge clk);
    #1;
    fresh = pre && out_valid;
  endtask

  task automatic do_reset();
    bit f;
    drive_idle();
    reset = 1'b1;
    tick(f);
    tick(f);
    reset = 1'b0;
    exp_q.delete();
    model_s = '0;
    last_s  = '0;
    last_c  = '0;
  endtask

  function automatic beat_t rand_beat();
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b1101, 4'b0111};
    return mk(DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
              DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
              codes[$urandom_range(7)], 2'($urandom_range(2)),
              ($urandom_range(3) == 0), 1'($urandom_range(1)));
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (S !== '0) begin errors++; $display("FAIL reset_S got=%h want=0", S); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++;
    if (carry_out !== '0) begin errors++; $display("FAIL reset_carry got=%h want=0", carry_out); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
  endtask

  task automatic test_full_add();
    bit f;
    drive(mk('0, '0, '0, 48'h0000_0000_0FFF, 4'b0000, 2'b00, 1'b0, 1'b1));
    tick(f);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_latency got=%b want=0", out_valid); end
    drive_idle();
    tick(f);
    checks++;
    if (!f || S !== 48'h0000_0000_1000 || carry_out !== '0) begin
      errors++;
      $display("FAIL full_add got S=%h c=%h v=%b want S=000000001000 c=00 v=1", S, carry_out, f);
    end
    exp_q.delete();
  endtask

  task automatic test_simd_isolation();
    bit f;
    drive(mk({NS{12'hFFF}}, {NS{12'hFFF}}, {NS{12'hFFF}}, {NS{12'hFFF}}, 4'b0000, 2'b10,
             1'b0, 1'b0));
    tick(f);
    drive_idle();
    tick(f);
    checks++;
    if (!f || S !== 48'hFFC_FFC_FFC_FFC || carry_out !== 8'hFF) begin
      errors++;
      $display("FAIL simd_iso got S=%h c=%h v=%b want S=ffcffcffcffc c=ff v=1", S, carry_out, f);
    end
    exp_q.delete();
  endtask

  task automatic test_sub_half();
    bit f;
    drive(mk('0, 48'h000002_000004, '0, 48'h000005_000003, 4'b0011, 2'b01, 1'b0, 1'b0));
    tick(f);
    drive_idle();
    tick(f);
    checks++;
    if (!f || S !== 48'h000003_FFFFFF) begin
      errors++;
      $display("FAIL sub_half got S=%h v=%b want S=000003ffffff v=1", S, f);
    end
    exp_q.delete();
  endtask

  task automatic test_accumulate();
    bit f;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(mk('0, 48'd5, '0, 48'h123, 4'b0000, 2'b00, 1'b1, 1'b0));
      else drive_idle();
      tick(f);
      if (i >= 1) begin
        checks++;
        if (!f || S !== DW'(5 * i)) begin
          errors++;
          $display("FAIL acc_step%0d got S=%0d v=%b want S=%0d v=1", i, S, f, 5 * i);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit   f;
    exp_t e;
    do_reset();
    for (int i = 0; i < 84; i++) begin
      if (i < 80 && $urandom_range(3) != 0) drive(rand_beat());
      else drive_idle();
      tick(f);
      if (f) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got S=%h want no result", S);
        end else begin
          e = exp_q.pop_front();
          if (S !== e.s || carry_out !== e.c) begin
            errors++;
            $display("FAIL b2b got S=%h c=%h want S=%h c=%h", S, carry_out, e.s, e.c);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_ce_stall();
    bit   f;
    exp_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ce = !(i >= 2 && i < 5);
      if (i < 2) drive(mk(48'd100 * (i + 1), 48'd7, 48'd1, 48'd50, 4'b0000, 2'b10, 1'b0, 1'b0));
      else drive_idle();
      tick(f);
      if (f) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra got S=%h want no result", S);
        end else begin
          e = exp_q.pop_front();
          last_s = e.s;
          last_c = e.c;
          if (S !== e.s || carry_out !== e.c) begin
            errors++;
            $display("FAIL stall_order got S=%h c=%h want S=%h c=%h", S, carry_out, e.s, e.c);
          end
        end
      end else if (i >= 2 && i < 5) begin
        checks++;
        if (out_valid !== 1'b1 || S !== last_s || carry_out !== last_c) begin
          errors++;
          $display("FAIL stall_hold got S=%h v=%b want S=%h v=1", S, out_valid, last_s);
        end
      end
    end
    ce = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drain got %0d pending want 0", exp_q.size());
    end
    drive(mk('0, 48'd9, '0, 48'd1, 4'b0000, 2'b00, 1'b0, 1'b0));
    tick(f);
    drive(mk('0, 48'd3, '0, 48'd1, 4'b0000, 2'b00, 1'b0, 1'b0));
    tick(f);
    drive_idle();
    reset = 1'b1;
    tick(f);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || S !== '0) begin
      errors++; $display("FAIL midreset got S=%h v=%b want S=0 v=0", S, out_valid);
    end
    exp_q.delete();
    model_s = '0;
    tick(f);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_discard got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal_mode();
    bit f;
    do_reset();
    drive(mk('0, '0, '0, 48'h0000_0000_0FFF, 4'b0000, 2'b11, 1'b0, 1'b1));
    tick(f);
    drive_idle();
    tick(f);
    checks++;
    if (!f || S !== 48'h0000_0000_1000 || carry_out !== '0) begin
      errors++;
      $display("FAIL illegal_result got S=%h c=%h v=%b want S=000000001000 c=00 v=1",
               S, carry_out, f);
    end
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b want=1", cfg_err); end
    drive(mk('0, 48'd1, '0, '0, 4'b0000, 2'b00, 1'b0, 1'b0));
    tick(f);
    drive_idle();
    tick(f);
    tick(f);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b want=1", cfg_err); end
    do_reset();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%b want=0", cfg_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    drive_idle();
    test_reset();
    test_full_add();
    test_simd_isolation();
    test_sub_half();
    test_accumulate();
    test_back_to_back();
    test_ce_stall();
    test_illegal_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
